// File: rtl/id_stage_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pipe_pkg
// Shared types and constants for the RV32I decode stage: widths, ALU op codes,
// branch and memory-op encodings, opcode[6:2] constants and the packed control
// bundle. The bundle is 21 bits wide. The low 17 bits hold, MSB first,
// {REG_we, SRC_A, SRC_B[1:0], ALU[4:0], BRANCH[2:0], MemtoReg, MEM_we,
// MEM_op[2:0]}. The top four bits are reserved and always zero.
// -----------------------------------------------------------------------------
package id_stage_pipe_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 16;
   localparam int CTRL_W     = 21;
   localparam int ALU_W      = 5;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD   = 5'd0,  ALU_SUB    = 5'd1,  ALU_SLL   = 5'd2,  ALU_SLT  = 5'd3,
      ALU_SLTU  = 5'd4,  ALU_XOR    = 5'd5,  ALU_SRL   = 5'd6,  ALU_SRA  = 5'd7,
      ALU_OR    = 5'd8,  ALU_AND    = 5'd9,  ALU_PASSB = 5'd10,
      ALU_MUL   = 5'd16, ALU_MULH   = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
      ALU_DIV   = 5'd20, ALU_DIVU   = 5'd21, ALU_REM   = 5'd22, ALU_REMU = 5'd23
   } alu_op_e;

   // BR_JUMP covers JAL and JALR; ex tells them apart from the opcode and SRC_A.
   typedef enum logic [2:0] {
      BR_NONE = 3'd0, BR_JUMP = 3'd1, BR_EQ  = 3'd2, BR_NE   = 3'd3,
      BR_LT   = 3'd4, BR_GE   = 3'd5, BR_LTU = 3'd6, BR_GEU  = 3'd7
   } branch_e;

   // MEM_op is the load/store funct3.
   typedef enum logic [2:0] {
      MEM_B = 3'b000, MEM_H = 3'b001, MEM_W = 3'b010, MEM_BU = 3'b100, MEM_HU = 3'b101
   } mem_op_e;

   // SRC_A: 0 = rs1, 1 = pc.  SRC_B: rs2, immediate, or constant 4 (link address).
   typedef enum logic [1:0] {
      SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2
   } src_b_e;

   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_FENCE  = 5'b00011;

   typedef struct packed {
      logic [3:0] rsvd;
      logic       reg_we;
      logic       src_a;
      src_b_e     src_b;
      alu_op_e    alu;
      branch_e    branch;
      logic       mem_to_reg;
      logic       mem_we;
      mem_op_e    mem_op;
   } ctrl_t;

   // Base integer ALU op from funct3; alt selects SUB/SRA.
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// -----------------------------------------------------------------------------
// id_stage_pipe_if
// Bundles every non-clock/reset signal of the decode stage: the if_id
// handshake and instruction, the register-file read port, and the ID/EX slot
// toward ex.
//   slave  : the decode stage (consumes i_*, drives o_*)
//   master : the environment around it (drives i_*, observes o_*)
// -----------------------------------------------------------------------------
interface id_stage_pipe_if;
   import id_stage_pipe_pkg::*;

   logic                  i_valid;
   logic                  o_ready;
   logic [XLEN-1:0]       i_pc_addr;
   logic [31:0]           i_inst_data;
   logic [REG_ADDR_W-1:0] o_reg1_r_addr;
   logic [REG_ADDR_W-1:0] o_reg2_r_addr;
   logic [XLEN-1:0]       i_reg1_r_data;
   logic [XLEN-1:0]       i_reg2_r_data;
   logic                  i_flush;
   logic                  i_ready;
   logic                  o_valid;
   logic [XLEN-1:0]       o_pc_addr;
   logic [31:0]           o_inst_data;
   logic [XLEN-1:0]       o_reg1_data;
   logic [XLEN-1:0]       o_reg2_data;
   logic [REG_ADDR_W-1:0] o_regd_addr;
   logic [XLEN-1:0]       o_imm_data;
   logic [CTRL_W-1:0]     o_ctrl;
   logic                  o_illegal;
   logic [CNT_W-1:0]      o_bubble_cnt;

   modport slave (
      input  i_valid, i_pc_addr, i_inst_data, i_reg1_r_data, i_reg2_r_data, i_flush, i_ready,
      output o_ready, o_reg1_r_addr, o_reg2_r_addr, o_valid, o_pc_addr, o_inst_data,
             o_reg1_data, o_reg2_data, o_regd_addr, o_imm_data, o_ctrl, o_illegal, o_bubble_cnt
   );

   modport master (
      output i_valid, i_pc_addr, i_inst_data, i_reg1_r_data, i_reg2_r_data, i_flush, i_ready,
      input  o_ready, o_reg1_r_addr, o_reg2_r_addr, o_valid, o_pc_addr, o_inst_data,
             o_reg1_data, o_reg2_data, o_regd_addr, o_imm_data, o_ctrl, o_illegal, o_bubble_cnt
   );
endinterface

// File: rtl/id_stage_pipe_id_decode.sv
// -----------------------------------------------------------------------------
// id_stage_pipe_id_decode
// Purely combinational RV32I decoder.
//   inst_i     : instruction word
//   imm_o      : sign-extended immediate (0 for formats without one)
//   ctrl_o     : control bundle (all zero when illegal_o)
//   illegal_o  : unrecognised opcode/funct combination
//   uses_rs1_o : instruction reads rs1 (hazard qualification)
//   uses_rs2_o : instruction reads rs2 (hazard qualification)
// Build option ID_MEXT_EN: when defined, OP with funct7=0000001 decodes as
// RV32M (ALU codes 16..23). Otherwise those encodings are illegal.
// -----------------------------------------------------------------------------
module id_stage_pipe_id_decode
   import id_stage_pipe_pkg::*;
(
   input  logic [31:0]       inst_i,
   output logic [XLEN-1:0]   imm_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              illegal_o,
   output logic              uses_rs1_o,
   output logic              uses_rs2_o
);

   logic [4:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   ctrl_t           c;
   ctrl_t           c_gated;
   logic            legal;
   logic            legal_s;

   assign opc = inst_i[6:2];
   assign f3  = inst_i[14:12];
   assign f7  = inst_i[31:25];

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'h000};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   assign uses_rs1_o = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
   assign uses_rs2_o = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

   // Opcode/funct decode into immediate, raw control fields and legality.
   always_comb begin
      c     = '0;
      imm_o = '0;
      legal = 1'b0;
      case (opc)
         OPC_LUI: begin
            imm_o = imm_u; c.reg_we = 1'b1; c.src_b = SRCB_IMM; c.alu = ALU_PASSB; legal = 1'b1;
         end
         OPC_AUIPC: begin
            imm_o = imm_u; c.reg_we = 1'b1; c.src_a = 1'b1; c.src_b = SRCB_IMM; legal = 1'b1;
         end
         OPC_JAL: begin
            imm_o = imm_j; c.reg_we = 1'b1; c.src_a = 1'b1; c.src_b = SRCB_FOUR;
            c.branch = BR_JUMP; legal = 1'b1;
         end
         OPC_JALR: begin
            imm_o = imm_i; c.reg_we = 1'b1; c.src_a = 1'b1; c.src_b = SRCB_FOUR;
            c.branch = BR_JUMP; legal = (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            // funct3 00x -> EQ/NE, 1xx -> LT/GE/LTU/GEU; 01x is unused.
            imm_o    = imm_b;
            c.alu    = ALU_SUB;
            c.branch = f3[2] ? branch_e'({1'b1, f3[1:0]}) : branch_e'({2'b01, f3[0]});
            legal    = (f3[2:1] != 2'b01);
         end
         OPC_LOAD: begin
            imm_o = imm_i; c.reg_we = 1'b1; c.src_b = SRCB_IMM; c.mem_to_reg = 1'b1;
            c.mem_op = mem_op_e'(f3);
            legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
         end
         OPC_STORE: begin
            imm_o = imm_s; c.src_b = SRCB_IMM; c.mem_we = 1'b1; c.mem_op = mem_op_e'(f3);
            legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
         end
         OPC_OPIMM: begin
            imm_o = imm_i; c.reg_we = 1'b1; c.src_b = SRCB_IMM;
            case (f3)
               3'b001:  begin c.alu = ALU_SLL; legal = (f7 == 7'b0000000); end
               3'b101:  begin
                  c.alu = alu_from_f3(f3, f7[5]);
                  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               end
               default: begin c.alu = alu_from_f3(f3, 1'b0); legal = 1'b1; end
            endcase
         end
         OPC_OP: begin
            c.reg_we = 1'b1; c.src_b = SRCB_RS2;
            case (f7)
               7'b0000000: begin c.alu = alu_from_f3(f3, 1'b0); legal = 1'b1; end
               7'b0100000: begin
                  c.alu = alu_from_f3(f3, 1'b1);
                  legal = (f3 == 3'b000) || (f3 == 3'b101);
               end
`ifdef ID_MEXT_EN
               7'b0000001: begin c.alu = alu_op_e'({2'b10, f3}); legal = 1'b1; end
`endif
               default:    legal = 1'b0;
            endcase
         end
         OPC_FENCE: legal = 1'b1;
         default:   legal = 1'b0;
      endcase
   end

   // Compressed encodings (inst[1:0] != 11) are not supported.
   assign legal_s = legal && (inst_i[1:0] == 2'b11);

   // Final bundle: no writes to x0, everything zero for an illegal instruction.
   always_comb begin
      c_gated        = c;
      c_gated.reg_we = c.reg_we && (inst_i[11:7] != 5'd0);
      if (legal_s) begin
         ctrl_o    = c_gated;
         illegal_o = 1'b0;
      end else begin
         ctrl_o    = '0;
         illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
// RV32I decode stage with a registered ID/EX slot, valid/ready flow control,
// flush, and load-use hazard detection that inserts one bubble per hazard.
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : id_stage_pipe_if.slave (if_id handshake, regfile read port,
//             ID/EX slot outputs, bubble counter)
// Build option ID_MEXT_EN enables RV32M decode in the decoder.
// -----------------------------------------------------------------------------
module id_stage_pipe
   import id_stage_pipe_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_reset,
   id_stage_pipe_if.slave bus
);

   logic [XLEN-1:0]       dec_imm;
   logic [CTRL_W-1:0]     dec_ctrl;
   logic                  dec_illegal;
   logic                  dec_uses_rs1;
   logic                  dec_uses_rs2;
   logic [REG_ADDR_W-1:0] rs1, rs2;
   logic                  adv, hazard, load_en;

   logic                  valid_q, valid_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]       pc_q, rs1d_q, rs2d_q, imm_q;
   logic [31:0]           inst_q;
   logic [REG_ADDR_W-1:0] rd_q;
   ctrl_t                 ctrl_q;
   logic                  illegal_q;

   id_stage_pipe_id_decode u_dec (
      .inst_i     (bus.i_inst_data),
      .imm_o      (dec_imm),
      .ctrl_o     (dec_ctrl),
      .illegal_o  (dec_illegal),
      .uses_rs1_o (dec_uses_rs1),
      .uses_rs2_o (dec_uses_rs2)
   );

   assign rs1 = bus.i_inst_data[19:15];
   assign rs2 = bus.i_inst_data[24:20];
   assign bus.o_reg1_r_addr = rs1;
   assign bus.o_reg2_r_addr = rs2;

   // The slot can take new contents when empty or when ex drains it this cycle.
   assign adv    = !valid_q || bus.i_ready;
   assign hazard = bus.i_valid && valid_q && ctrl_q.mem_to_reg && (rd_q != 5'd0) &&
                   ((dec_uses_rs1 && (rs1 == rd_q)) || (dec_uses_rs2 && (rs2 == rd_q)));
   // A flush consumes (and drops) the input regardless of the slot state.
   assign bus.o_ready = bus.i_flush || (adv && !hazard);

   // Slot next-state: flush > bubble > advance > hold.
   always_comb begin
      valid_d = valid_q;
      cnt_d   = cnt_q;
      load_en = 1'b0;
      if (bus.i_flush) begin
         valid_d = 1'b0;
      end else if (adv && hazard) begin
         valid_d = 1'b0;
         cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      end else if (adv) begin
         valid_d = bus.i_valid;
         load_en = bus.i_valid;
      end else begin
         valid_d = valid_q;
      end
   end

   // ID/EX slot registers; payload only moves when a valid instruction is taken.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         pc_q      <= '0;
         inst_q    <= '0;
         rs1d_q    <= '0;
         rs2d_q    <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         if (load_en) begin
            pc_q      <= bus.i_pc_addr;
            inst_q    <= bus.i_inst_data;
            rs1d_q    <= bus.i_reg1_r_data;
            rs2d_q    <= bus.i_reg2_r_data;
            rd_q      <= bus.i_inst_data[11:7];
            imm_q     <= dec_imm;
            ctrl_q    <= ctrl_t'(dec_ctrl);
            illegal_q <= dec_illegal;
         end
      end
   end

   assign bus.o_valid      = valid_q;
   assign bus.o_pc_addr    = pc_q;
   assign bus.o_inst_data  = inst_q;
   assign bus.o_reg1_data  = rs1d_q;
   assign bus.o_reg2_data  = rs2d_q;
   assign bus.o_regd_addr  = rd_q;
   assign bus.o_imm_data   = imm_q;
   assign bus.o_ctrl       = ctrl_q;
   assign bus.o_illegal    = illegal_q;
   assign bus.o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipe
// Self-checking bench for id_stage_pipe. A vector table of instructions with
// hand-derived immediates/control bundles is issued through the handshake;
// each accepted instruction pushes its expected slot contents to a scoreboard
// queue, which is popped when the slot is handed to ex. Hand-written sequences
// cover load-use bubbles, flush, back-pressure and asynchronous reset.
// Control bundle layout: {4'b0, REG_we, SRC_A, SRC_B[1:0], ALU[4:0],
// BRANCH[2:0], MemtoReg, MEM_we, MEM_op[2:0]}.
// -----------------------------------------------------------------------------
module tb_id_stage_pipe;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [20:0] ctrl;
      logic        ill;
      logic [4:0]  rd;
   } vec_t;

   typedef struct {
      logic [31:0] pc, inst, r1, r2, imm;
      logic [20:0] ctrl;
      logic        ill;
      logic [4:0]  rd;
   } exp_t;

   logic        clk;
   logic        rst_n;
   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] pc_r = 32'h0000_1000;
   vec_t        tbl [15];
   vec_t        v_lw2, v_add, v_lw0, v_add0, v_lw8;

   id_stage_pipe_if bus ();

   id_stage_pipe dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input vec_t v, input logic [31:0] pc,
                                   input logic [31:0] d1, input logic [31:0] d2);
      exp_t e;
      e.pc = pc; e.inst = v.inst; e.r1 = d1; e.r2 = d2;
      e.imm = v.imm; e.ctrl = v.ctrl; e.ill = v.ill; e.rd = v.rd;
      return e;
   endfunction

   // Drive one instruction from just after a rising edge until accepted.
   task automatic send(input vec_t v, input logic flush, output int waits, output logic v_acc);
      logic        acc;
      logic [31:0] d1, d2;
      d1 = $urandom; d2 = $urandom;
      pc_r = pc_r + 32'd4;
      bus.i_valid = 1'b1; bus.i_inst_data = v.inst; bus.i_pc_addr = pc_r;
      bus.i_reg1_r_data = d1; bus.i_reg2_r_data = d2; bus.i_flush = flush;
      waits = 0; acc = 1'b0; v_acc = 1'b0;
      for (int n = 0; n < 10 && !acc; n++) begin
         @(negedge clk);
         acc   = bus.o_ready;
         v_acc = bus.o_valid;
         if (acc) begin
            chk("rs1_addr", 32'(bus.o_reg1_r_addr), 32'(v.inst[19:15]));
            chk("rs2_addr", 32'(bus.o_reg2_r_addr), 32'(v.inst[24:20]));
            if (!flush) sb.push_back(mk_exp(v, pc_r, d1, d2));
         end else begin
            waits++;
         end
         @(posedge clk); #1;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      bus.i_valid = 1'b0; bus.i_flush = 1'b0;
   endtask

   task automatic drain(input string tag);
      repeat (3) begin @(posedge clk); #1; end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   // Scoreboard: compare the slot whenever ex takes it.
   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.i_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("pc",      bus.o_pc_addr,           mon_e.pc);
            chk("inst",    bus.o_inst_data,         mon_e.inst);
            chk("rs1_data", bus.o_reg1_data,        mon_e.r1);
            chk("rs2_data", bus.o_reg2_data,        mon_e.r2);
            chk("imm",     bus.o_imm_data,          mon_e.imm);
            chk("ctrl",    32'(bus.o_ctrl),         32'(mon_e.ctrl));
            chk("illegal", 32'(bus.o_illegal),      32'(mon_e.ill));
            chk("rd",      32'(bus.o_regd_addr),    32'(mon_e.rd));
         end
      end
   end

   initial begin
      int   w;
      logic va;
      logic [31:0] d1, d2;

      tbl[0]  = '{32'h00500093, 32'd5,        21'h12000, 1'b0, 5'd1};   // addi x1,x0,5
      tbl[1]  = '{32'h0000A103, 32'd0,        21'h12012, 1'b0, 5'd2};   // lw x2,0(x1)
      tbl[2]  = '{32'h40628233, 32'd0,        21'h10100, 1'b0, 5'd4};   // sub x4,x5,x6
      tbl[3]  = '{32'h123453B7, 32'h12345000, 21'h12A00, 1'b0, 5'd7};   // lui x7,0x12345
      tbl[4]  = '{32'h00001417, 32'h00001000, 21'h1A000, 1'b0, 5'd8};   // auipc x8,1
      tbl[5]  = '{32'h008000EF, 32'd8,        21'h1C020, 1'b0, 5'd1};   // jal x1,+8
      tbl[6]  = '{32'hFE21AE23, 32'hFFFFFFFC, 21'h0200A, 1'b0, 5'd28};  // sw x2,-4(x3)
      tbl[7]  = '{32'hFE000EE3, 32'hFFFFFFFC, 21'h00140, 1'b0, 5'd29};  // beq x0,x0,-4
      tbl[8]  = '{32'h40355493, 32'h00000403, 21'h12700, 1'b0, 5'd9};   // srai x9,x10,3
      tbl[9]  = '{32'h00000013, 32'd0,        21'h02000, 1'b0, 5'd0};   // nop (rd=x0)
      tbl[10] = '{32'h0FF0000F, 32'd0,        21'h00000, 1'b0, 5'd0};   // fence
      tbl[11] = '{32'h00000000, 32'd0,        21'h00000, 1'b1, 5'd0};   // all zero
`ifdef ID_MEXT_EN
      tbl[12] = '{32'h027302B3, 32'd0,        21'h11000, 1'b0, 5'd5};   // mul x5,x6,x7
`else
      tbl[12] = '{32'h027302B3, 32'd0,        21'h00000, 1'b1, 5'd5};   // mul x5,x6,x7
`endif
      tbl[13] = '{32'h00000073, 32'd0,        21'h00000, 1'b1, 5'd0};   // ecall
      tbl[14] = '{32'h004280E7, 32'd4,        21'h1C020, 1'b0, 5'd1};   // jalr x1,4(x5)

      v_lw2  = tbl[1];
      v_add  = '{32'h001101B3, 32'd0, 21'h10000, 1'b0, 5'd3};   // add x3,x2,x1
      v_lw0  = '{32'h0000A003, 32'd0, 21'h02012, 1'b0, 5'd0};   // lw x0,0(x1)
      v_add0 = '{32'h001001B3, 32'd0, 21'h10000, 1'b0, 5'd3};   // add x3,x0,x1
      v_lw8  = '{32'h0000A403, 32'd0, 21'h12012, 1'b0, 5'd8};   // lw x8,0(x1)

      bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_ready = 1'b1;
      bus.i_inst_data = 32'd0; bus.i_pc_addr = 32'd0;
      bus.i_reg1_r_data = 32'd0; bus.i_reg2_r_data = 32'd0;
      rst_n = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_ctrl",  32'(bus.o_ctrl), 32'd0);
      chk("rst_cnt",   32'(bus.o_bubble_cnt), 32'd0);
      chk("rst_imm",   bus.o_imm_data, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Vector table, ex always ready, no hazards between neighbours
      foreach (tbl[i]) begin
         send(tbl[i], 1'b0, w, va);
         chk("tbl_stall", 32'(w), 32'd0);
      end
      drain("tbl_drain");
      chk("tbl_cnt", 32'(bus.o_bubble_cnt), 32'd0);

      // Load-use through rs1: one stall, bubble, then the add
      send(v_lw2, 1'b0, w, va);
      send(v_add, 1'b0, w, va);
      chk("lu_stall", 32'(w), 32'd1);
      chk("lu_bubble", 32'(va), 32'd0);
      drain("lu_drain");
      chk("lu_cnt", 32'(bus.o_bubble_cnt), 32'd1);

      // Load to x0 is never a hazard
      send(v_lw0, 1'b0, w, va);
      send(v_add0, 1'b0, w, va);
      chk("x0_stall", 32'(w), 32'd0);
      // lui's rs1 field matches the load rd but lui reads no register
      send(v_lw8, 1'b0, w, va);
      send(tbl[3], 1'b0, w, va);
      chk("lui_stall", 32'(w), 32'd0);
      // Load-use through rs2 only (store data)
      send(v_lw2, 1'b0, w, va);
      send(tbl[6], 1'b0, w, va);
      chk("rs2_stall", 32'(w), 32'd1);
      drain("rs2_drain");
      chk("rs2_cnt", 32'(bus.o_bubble_cnt), 32'd2);

      // Flush during acceptance drops the instruction
      send(tbl[7], 1'b0, w, va);
      send(tbl[0], 1'b1, w, va);
      chk("flush_ready", 32'(w), 32'd0);
      @(negedge clk);
      chk("flush_valid", 32'(bus.o_valid), 32'd0);
      chk("flush_ready_after", 32'(bus.o_ready), 32'd1);
      @(posedge clk); #1;
      // Flush wins over a load-use hazard: no stall, no bubble counted
      send(v_lw2, 1'b0, w, va);
      send(v_add, 1'b1, w, va);
      chk("flush_hz_stall", 32'(w), 32'd0);
      @(negedge clk);
      chk("flush_hz_valid", 32'(bus.o_valid), 32'd0);
      @(posedge clk); #1;
      drain("flush_drain");
      chk("flush_hz_cnt", 32'(bus.o_bubble_cnt), 32'd2);

      // Back-pressure: slot full, ex not ready, new instruction waits
      send(tbl[0], 1'b0, w, va);
      bus.i_ready = 1'b0;
      d1 = $urandom; d2 = $urandom;
      pc_r = pc_r + 32'd4;
      bus.i_valid = 1'b1; bus.i_inst_data = tbl[3].inst; bus.i_pc_addr = pc_r;
      bus.i_reg1_r_data = d1; bus.i_reg2_r_data = d2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready", 32'(bus.o_ready), 32'd0);
         chk("bp_valid", 32'(bus.o_valid), 32'd1);
         chk("bp_inst", bus.o_inst_data, tbl[0].inst);
         chk("bp_imm", bus.o_imm_data, tbl[0].imm);
         chk("bp_ctrl", 32'(bus.o_ctrl), 32'(tbl[0].ctrl));
         @(posedge clk); #1;
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(bus.o_ready), 32'd1);
      if (bus.o_ready) sb.push_back(mk_exp(tbl[3], pc_r, d1, d2));
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      drain("bp_drain");

      // Asynchronous reset mid-stream with the slot full
      send(tbl[0], 1'b0, w, va);
      bus.i_ready = 1'b0;
      chk("mid_valid_before", 32'(bus.o_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
      chk("mid_rst_cnt", 32'(bus.o_bubble_cnt), 32'd0);
      chk("mid_rst_ctrl", 32'(bus.o_ctrl), 32'd0);
      chk("mid_rst_imm", bus.o_imm_data, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      send(tbl[8], 1'b0, w, va);
      drain("post_rst_drain");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
RV32I instruction decode stage with an integrated, registered ID/EX pipeline slot, valid/ready flow control, and flush. It decodes the instruction into immediate and control bundle, captures register-file read data, and detects load-use hazards. On a load-use hazard it inserts exactly one bubble toward EX. It sits between if_id and ex and replaces the purely combinational decoder.

Parameters:
XLEN, 32, data/address/immediate width
REG_ADDR_W, 5, register index width
CNT_W, 16, width of bubble performance counter

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_valid  in  1  if_id holds a valid instruction
o_ready  out  1  decode accepts the instruction this cycle
i_pc_addr  in  XLEN  pc of incoming instruction
i_inst_data  in  32  incoming instruction
o_reg1_r_addr  out  REG_ADDR_W  rs1 to regs (combinational = inst[19:15])
o_reg2_r_addr  out  REG_ADDR_W  rs2 to regs (combinational = inst[24:20])
i_reg1_r_data  in  XLEN  rs1 data (regs is write-through)
i_reg2_r_data  in  XLEN  rs2 data
i_flush  in  1  branch/jump redirect from ex
i_ready  in  1  ex accepts slot contents
o_valid  out  1  slot holds a valid decoded instruction
o_pc_addr, o_inst_data  out  XLEN, 32  registered copies
o_reg1_data, o_reg2_data  out  XLEN  registered operand data
o_regd_addr  out  REG_ADDR_W  rd
o_imm_data  out  XLEN  sign-extended immediate
o_ctrl  out  CTRL_W  {REG_we, SRC_A, SRC_B[1:0], ALU[4:0], BRANCH[2:0], MemtoReg, MEM_we, MEM_op[2:0]}
o_illegal  out  1  slot holds an unrecognised opcode/funct
o_bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (i_reset low, async): o_valid=0; all payload outputs, o_ctrl, o_illegal, and o_bubble_cnt are 0.
- Slot states: EMPTY (o_valid=0) and FULL (o_valid=1). adv = !o_valid | i_ready.
- hazard = i_valid & o_valid & o_ctrl.MemtoReg & (o_regd_addr!=0) & ((uses_rs1 & rs1==o_regd_addr) | (uses_rs2 & rs2==o_regd_addr)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: R-type, S-type, B-type.
- o_ready = i_flush | (adv & !hazard).
- Clock edge priority:
  1. i_flush: o_valid<=0. The input is consumed and dropped. Flush wins over hazard and i_ready.
  2. Else adv & hazard: o_valid<=0 (bubble) and o_bubble_cnt increments, saturating at all-ones. The input is held and accepted the next cycle from EMPTY, so exactly one bubble per hazard.
  3. Else adv: o_valid<=i_valid. Payload is loaded only when i_valid.
  4. Else (FULL & !i_ready): hold all outputs.
- Latency: one cycle from acceptance to o_valid.
- Immediate by opcode[6:2]:
  - I: 11001, 00100, 00000
  - U: 01101, 00101
  - S: 01000
  - B: 11000
  - J: 11011
  - else 0
- ALU codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
  - SUB/SRA are selected by funct7[5] (SUB only for R-type).
- REG_we is forced to 0 when rd==0 or the instruction is illegal.
- Illegal instruction: o_ctrl=0, o_illegal=1, o_valid=1, so ex can trap.
- FENCE decodes as a NOP (legal).

Optional Feature:
ID_MEXT_EN
- Defined: R-type with funct7=0000001 decodes as RV32M, ALU codes 16..23 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), REG_we=1.
- Undefined: those encodings set o_illegal=1.

Decomposition:
- Shared package (extend defines.v): CTRL_W=21, ALU_W=5, ALU op codes, BRANCH and MEM_op encodings, opcode constants, ctrl field bit positions.
- One natural sub-module: id_decode. It is purely combinational (inst -> imm, ctrl, illegal, uses_rs1, uses_rs2). id_stage_pipe holds the slot register, handshake, hazard logic, and counter.

Test Plan:
1. Reset low mid-stream with o_valid=1 -> o_valid=0 and o_bubble_cnt=0 immediately, without waiting for i_clk.
2. 0x00500093 (addi x1,x0,5), i_ready=1 -> next cycle o_valid=1, o_imm_data=5, ALU=ADD, SRC_B=imm, REG_we=1, o_regd_addr=1.
3. 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) -> o_ready=0 for one cycle, one bubble (o_valid=0), add issues the following cycle, o_bubble_cnt=1.
4. 0xFE000EE3 (beq x0,x0,-4) -> o_imm_data=0xFFFFFFFC. i_flush during acceptance of the next instruction -> o_valid=0 next cycle, o_ready=1.
5. i_ready=0 with slot FULL and new i_valid -> o_ready=0, all outputs held stable for 3 cycles. Release i_ready -> new instruction loads.
6. 0x027302B3 (mul x5,x6,x7) -> with ID_MEXT_EN: ALU=16, o_illegal=0. Without: o_illegal=1, o_ctrl=0. Also 0x00000000 -> o_illegal=1 in both builds.
